// File: rtl/ext_trig_pkg.sv
// ext_trig_pkg
// Shared types and defaults for the external trigger pin controller.
//   trig_state_e     : controller state encoding
//   SYNC_STAGES_DEF  : default synchronizer depth on the pin input
//   TURN_CYCLES_DEF  : default post-drive turnaround length
//   CNT_W_DEF        : default event counter width
//   TMR_W            : width of the shared down-counter timer
package ext_trig_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int TURN_CYCLES_DEF = 4;
    localparam int CNT_W_DEF       = 16;

    // Wide enough for the 16-bit holdoff, which is the longest load value.
    localparam int TMR_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        TURN    = 3'd2,
        RX_WAIT = 3'd3,
        HOLDOFF = 3'd4
    } trig_state_e;

endpackage

// File: rtl/trig_sync_edge.sv
// trig_sync_edge
// STAGES-deep synchronizer followed by a rising-edge detector.
//   clk   : system clock
//   rst   : synchronous active-high reset, clears every flop
//   din   : asynchronous input
//   level : synchronized level (last synchronizer stage)
//   rise  : high for one cycle when level goes 0 -> 1
module trig_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], din};
            level_d <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~level_d;

endmodule

// File: rtl/ext_trig_ctrl.sv
// ext_trig_ctrl
// Arbitrates the shared bidirectional trigger line between boards: drives a
// local pixel trigger out, or accepts a remote one, with turnaround and
// holdoff windows so a board never hears its own pulse or fights a remote
// driver.
//   clk, rst        : system clock, synchronous active-high reset
//   enable          : block enable; low stops new drive/receive
//   pixel_trig      : local trigger request (rising edge acts)
//   drive_width     : drive length in cycles (0 behaves as 1)
//   holdoff         : dead time after every TX or RX event
//   ext_trig_in     : pin input from the IOBUF (asynchronous)
//   ext_trig_t      : IOBUF tristate control, 1 = released, 0 = drive high
//   ext_trig_rx     : one-cycle pulse per accepted external trigger
//   busy            : high whenever not IDLE
//   tx/rx/drop_count: saturating event counters
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | line released, accepting local or remote triggers
// DRIVE   | line driven high for max(drive_width,1) cycles
// TURN    | line released, input ignored while our own pulse drains away
// RX_WAIT | remote pulse accepted, waiting for the line to go low
// HOLDOFF | dead time before the next event may be accepted
module ext_trig_ctrl
    import ext_trig_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TURN_CYCLES = TURN_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pixel_trig,
    input  logic [7:0]       drive_width,
    input  logic [15:0]      holdoff,
    input  logic             ext_trig_in,
    output logic             ext_trig_t,
    output logic             ext_trig_rx,
    output logic             busy,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam logic [TMR_W-1:0] TURN_LOAD = TMR_W'(TURN_CYCLES - 1);

    trig_state_e      state, state_nxt, after_wait;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [TMR_W-1:0] drive_load, hold_load;
    logic             ext_level, ext_rise;
    logic             pix_q, pix_rise;
    logic             rx_nxt, tx_inc, rx_inc, drop_inc;

    trig_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ext_trig_in),
        .level (ext_level),
        .rise  (ext_rise)
    );

    // pixel_trig is already in the clk domain, so only the edge detect is needed.
    assign pix_rise = pixel_trig & ~pix_q;

    // Timers count down to zero; the load value is length-1.
    assign drive_load = (drive_width == 8'd0) ? '0 : TMR_W'(drive_width - 8'd1);
    assign hold_load  = holdoff - 16'd1;

    // Where TURN/RX_WAIT go when they finish: a zero holdoff skips HOLDOFF,
    // and a disabled block winds straight back to IDLE.
    assign after_wait = (!enable || holdoff == 16'd0) ? IDLE : HOLDOFF;

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        rx_nxt    = 1'b0;
        tx_inc    = 1'b0;
        rx_inc    = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    if (ext_rise) begin
                        // Remote wins a same-cycle collision.
                        state_nxt = RX_WAIT;
                        rx_nxt    = 1'b1;
                        rx_inc    = 1'b1;
                        drop_inc  = pix_rise;
                    end else if (pix_rise) begin
                        if (ext_level) begin
                            drop_inc = 1'b1;
                        end else begin
                            state_nxt = DRIVE;
                            tmr_nxt   = drive_load;
                            tx_inc    = 1'b1;
                        end
                    end
                end
            end
            DRIVE: begin
                drop_inc = pix_rise & enable;
                if (!enable || tmr == '0) begin
                    state_nxt = TURN;
                    tmr_nxt   = TURN_LOAD;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            TURN: begin
                drop_inc = pix_rise & enable;
                if (tmr == '0) begin
                    state_nxt = after_wait;
                    tmr_nxt   = hold_load;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            RX_WAIT: begin
                drop_inc = pix_rise & enable;
                if (!ext_level) begin
                    state_nxt = after_wait;
                    tmr_nxt   = hold_load;
                end
            end
            HOLDOFF: begin
                drop_inc = pix_rise & enable;
                if (tmr == '0) begin
                    state_nxt = IDLE;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so the pin control changes
    // on the same edge the state does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tmr         <= '0;
            pix_q       <= 1'b0;
            ext_trig_t  <= 1'b1;
            ext_trig_rx <= 1'b0;
            busy        <= 1'b0;
            tx_count    <= '0;
            rx_count    <= '0;
            drop_count  <= '0;
        end else begin
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            pix_q       <= pixel_trig;
            ext_trig_t  <= (state_nxt != DRIVE);
            ext_trig_rx <= rx_nxt;
            busy        <= (state_nxt != IDLE);
            if (tx_inc && tx_count != '1) begin
                tx_count <= tx_count + CNT_W'(1);
            end
            if (rx_inc && rx_count != '1) begin
                rx_count <= rx_count + CNT_W'(1);
            end
            if (drop_inc && drop_count != '1) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ext_trig_ctrl.sv
// tb_ext_trig_ctrl
// Scoreboard bench for ext_trig_ctrl. The stimulus process runs an
// event-level reference model (accept times, busy windows, pin history) and
// queues the expected TX drive windows and RX pulses; a monitor pops them as
// the DUT produces them. A second instance with 4-bit counters shares the
// stimulus to exercise counter saturation cheaply.
module tb_ext_trig_ctrl;
    import ext_trig_pkg::*;

    localparam int TURN  = 4;
    localparam int SAT_W = 4;
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    logic        clk = 1'b0;
    logic        rst, enable, pixel_trig, ext_trig_in;
    logic [7:0]  drive_width;
    logic [15:0] holdoff;

    logic        ext_trig_t, ext_trig_rx, busy;
    logic [15:0] tx_count, rx_count, drop_count;
    logic        sat_t, sat_rx, sat_busy;
    logic [SAT_W-1:0] sat_tx, sat_rxc, sat_drop;

    ext_trig_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .pixel_trig(pixel_trig),
        .drive_width(drive_width), .holdoff(holdoff), .ext_trig_in(ext_trig_in),
        .ext_trig_t(ext_trig_t), .ext_trig_rx(ext_trig_rx), .busy(busy),
        .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count)
    );

    ext_trig_ctrl #(.CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .pixel_trig(pixel_trig),
        .drive_width(drive_width), .holdoff(holdoff), .ext_trig_in(ext_trig_in),
        .ext_trig_t(sat_t), .ext_trig_rx(sat_rx), .busy(sat_busy),
        .tx_count(sat_tx), .rx_count(sat_rxc), .drop_count(sat_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int sat(int v);
        return (v > SAT_MAX) ? SAT_MAX : v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int start; int width; } tx_exp_t;
    tx_exp_t tx_q[$];
    int      rx_q[$];

    int m_free_at = 0;          // first edge at which a new event may be accepted
    bit m_rx_wait = 1'b0;       // remote pulse accepted, line not yet seen low
    int m_tx = 0, m_rx = 0, m_drop = 0;
    bit m_pix_prev = 1'b0;
    bit pin_h1 = 1'b0, pin_h2 = 1'b0, pin_h3 = 1'b0;   // pin sampled 1,2,3 edges ago

    // Evaluated with the inputs the DUT sampled at edge k.
    function automatic void model_edge(int k);
        bit lvl, erise, prise, idle;
        int w;
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            m_free_at  = k + 1;
            m_rx_wait  = 1'b0;
            m_tx = 0; m_rx = 0; m_drop = 0;
            m_pix_prev = 1'b0;
            pin_h1 = 1'b0; pin_h2 = 1'b0; pin_h3 = 1'b0;
            return;
        end
        // The controller sees the pin two edges late (synchronizer depth).
        lvl   = pin_h2;
        erise = pin_h2 & ~pin_h3;
        prise = pixel_trig & ~m_pix_prev;
        idle  = !m_rx_wait && (k >= m_free_at);
        if (m_rx_wait && !lvl) begin
            m_rx_wait = 1'b0;
            m_free_at = k + 1 + int'(holdoff);
        end
        if (idle && enable) begin
            if (erise) begin
                m_rx++;
                rx_q.push_back(k);
                m_rx_wait = 1'b1;
                if (prise) m_drop++;
            end else if (prise) begin
                if (lvl) begin
                    m_drop++;
                end else begin
                    w = (drive_width == 8'd0) ? 1 : int'(drive_width);
                    m_tx++;
                    tx_q.push_back('{k, w});
                    m_free_at = k + w + TURN + int'(holdoff) + 1;
                end
            end
        end else if (!idle && prise && enable) begin
            m_drop++;
        end
        m_pix_prev = pixel_trig;
        pin_h3 = pin_h2;
        pin_h2 = pin_h1;
        pin_h1 = ext_trig_in;
    endfunction

    // ---------------- stimulus helpers ----------------
    logic t_h1 = 1'b1, t_h2 = 1'b1;
    int   t_low_cnt = 0;

    task automatic step(input logic p, input logic e);
        pixel_trig  = p;
        ext_trig_in = e;
        @(posedge clk);
        #1;
        model_edge(cyc);
        t_h2 = t_h1;
        t_h1 = ext_trig_t;
        if (!ext_trig_t) t_low_cnt++;
    endtask

    // Pin follows the driven level two cycles late, like a reflection.
    task automatic step_loop(input logic p);
        step(p, ~t_h2);
    endtask

    task automatic check_counts(string tag);
        check({tag, "_tx_count"},   tx_count,   m_tx);
        check({tag, "_rx_count"},   rx_count,   m_rx);
        check({tag, "_drop_count"}, drop_count, m_drop);
        check({tag, "_tx_queue"},   tx_q.size(), 0);
        check({tag, "_rx_queue"},   rx_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    bit mon_on = 1'b0;
    bit t_prev = 1'b1;
    int low_start = 0;
    int exp_w = 0;

    initial begin
        tx_exp_t te;
        int      re;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (ext_trig_rx) begin
                    if (rx_q.size() == 0) check("rx_unexpected_pulse", cyc, -1);
                    else begin
                        re = rx_q.pop_front();
                        check("rx_pulse_cycle", cyc, re);
                    end
                end
                if (t_prev && !ext_trig_t) begin
                    if (tx_q.size() == 0) begin
                        check("tx_unexpected_drive", cyc, -1);
                        exp_w = -1;
                    end else begin
                        te = tx_q.pop_front();
                        check("tx_drive_start", cyc, te.start);
                        exp_w = te.width;
                    end
                    low_start = cyc;
                end
                if (!t_prev && ext_trig_t) check("tx_drive_width", cyc - low_start, exp_w);
            end
            t_prev = ext_trig_t;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int  b_cnt, d0, r0, tl0, run;
        bit  pv, lp;
        rst = 1'b1; enable = 1'b1; pixel_trig = 1'b0; ext_trig_in = 1'b0;
        drive_width = 8'd5; holdoff = 16'd10;

        repeat (3) step(1'b0, 1'b1);
        check("reset_t", ext_trig_t, 1);
        check("reset_rx", ext_trig_rx, 0);
        check("reset_busy", busy, 0);
        check("reset_tx_count", tx_count, 0);
        check("reset_rx_count", rx_count, 0);
        check("reset_drop_count", drop_count, 0);
        rst = 1'b0;
        step(1'b0, 1'b0);
        mon_on = 1'b1;

        // Basic TX: 5 drive + 4 turn + 10 holdoff cycles busy.
        b_cnt = 0; tl0 = t_low_cnt;
        step(1'b1, 1'b0);
        if (busy) b_cnt++;
        repeat (30) begin
            step(1'b0, 1'b0);
            if (busy) b_cnt++;
        end
        check("tx_basic_busy_cycles", b_cnt, 19);
        check("tx_basic_low_cycles", t_low_cnt - tl0, 5);
        check("tx_basic_tx_count", tx_count, 1);

        // Local edge landing in HOLDOFF is dropped.
        d0 = drop_count;
        step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);
        check("holdoff_drop", drop_count - d0, 1);

        // Basic RX: pin high for 20 cycles.
        r0 = rx_count;
        repeat (20) step(1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0);
        check("rx_basic_count", rx_count - r0, 1);

        // Collision: pin edge and local edge reach the FSM on the same cycle.
        d0 = drop_count; r0 = rx_count; tl0 = t_low_cnt;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0);
        check("collision_drop", drop_count - d0, 1);
        check("collision_rx", rx_count - r0, 1);
        check("collision_no_drive", t_low_cnt - tl0, 0);

        // drive_width = 0 gives a one-cycle drive.
        drive_width = 8'd0; tl0 = t_low_cnt;
        step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);
        check("dw0_low_cycles", t_low_cnt - tl0, 1);

        // Self-echo: reflected pulse must never be taken as a remote trigger.
        drive_width = 8'd3; holdoff = 16'd0; r0 = rx_count;
        repeat (6) begin
            step_loop(1'b1);
            repeat (14) step_loop(1'b0);
        end
        repeat (10) step(1'b0, 1'b0);
        check("self_echo_rx", rx_count - r0, 0);
        check_counts("directed");

        // Randomized segments, one of them with the pin looped back.
        pv = 1'b0; run = 0;
        for (int seg = 0; seg < 6; seg++) begin
            drive_width = 8'($urandom_range(0, 7));
            holdoff     = 16'($urandom_range(0, 12));
            lp = (seg == 2);
            repeat (300) begin
                if (run == 0) begin
                    pv  = ~pv;
                    run = pv ? $urandom_range(1, 25) : $urandom_range(1, 40);
                end
                run--;
                if (lp) step_loop($urandom_range(0, 3) == 0);
                else    step($urandom_range(0, 3) == 0, pv);
            end
            pv = 1'b0; run = 0;
            repeat (40) step(1'b0, 1'b0);
            check_counts("random");
        end

        // Enable dropped mid-drive releases the line on the next edge.
        drive_width = 8'd8; holdoff = 16'd3; mon_on = 1'b0;
        step(1'b1, 1'b0);
        check("en_drive_active", ext_trig_t, 0);
        step(1'b0, 1'b0);
        enable = 1'b0;
        step(1'b0, 1'b0);
        check("en_drop_release", ext_trig_t, 1);
        repeat (30) step(1'b0, 1'b0);
        check("en_drop_idle", busy, 0);
        enable = 1'b1;
        tx_q.delete();
        mon_on = 1'b1;
        step(1'b0, 1'b0);

        // Reset mid-drive.
        mon_on = 1'b0;
        step(1'b1, 1'b0);
        check("rst_drive_active", ext_trig_t, 0);
        rst = 1'b1;
        step(1'b0, 1'b0);
        check("rst_release", ext_trig_t, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_count", tx_count, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_drop_count", drop_count, 0);
        rst = 1'b0;
        step(1'b0, 1'b0);
        mon_on = 1'b1;

        // Drop storm with the line held high: saturates the narrow counters.
        holdoff = 16'd2;
        repeat (3) step(1'b0, 1'b1);
        repeat (20) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
        end
        repeat (15) step(1'b0, 1'b0);
        check_counts("storm");
        check("sat_drop_count", sat_drop, sat(m_drop));
        check("sat_tx_count", sat_tx, sat(m_tx));
        check("sat_rx_count", sat_rxc, sat(m_rx));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ext_trig_ctrl.md
# ext_trig_ctrl

Sequencing controller for the shared, bidirectional external trigger pin between QuaBo boards. It decides cycle by cycle whether the IOBUF drives the line (local pixel trigger out) or listens (external trigger in). It also applies turnaround and holdoff windows so a board never hears its own pulse or drives into a remote driver. It sits between the MAROC pixel-trigger logic and the ext_trig IOBUF wrapper, and supplies that wrapper's tristate control.

## Interface
- SYNC_STAGES, 2: synchronizer flops on the pin input (min 2)
- TURN_CYCLES, 4: post-drive turnaround cycles during which the input is ignored
- CNT_W, 16: width of the event counters
- clk  in  1  system clock; all logic is in this single clock domain
- rst  in  1  synchronous, active-high reset
- enable  in  1  block enable; when low, no drive and no reception
- pixel_trig  in  1  local trigger request, synchronous to clk; acts on its rising edge
- drive_width  in  8  drive pulse length in cycles; 0 is treated as 1
- holdoff  in  16  dead time in cycles after every TX or RX event
- ext_trig_in  in  1  IOBUF O output; asynchronous
- ext_trig_t  out  1  IOBUF T control; 1 = input/released, 0 = drive high
- ext_trig_rx  out  1  one-cycle pulse on an accepted external trigger
- busy  out  1  high whenever the state is not IDLE
- tx_count, rx_count, drop_count  out  CNT_W  saturating event counters

## Operation
- Input path: ext_trig_in passes through SYNC_STAGES flops, then a rising-edge detect.
- pixel_trig: rising-edge detect against the previous-cycle register.
- IDLE: ext_trig_t = 1.
  - Synced input rising edge → pulse ext_trig_rx, increment rx_count, go to RX_WAIT.
  - Otherwise, local edge while synced input is low → go to DRIVE, increment tx_count.
  - Local edge while synced input is high (line busy) → request dropped, increment drop_count.
  - Simultaneous local and external edges → external wins; local is dropped and drop_count increments.
- DRIVE: ext_trig_t = 0 for max(drive_width,1) cycles, then go to TURN.
  - drive_width is sampled on entry to DRIVE.
- TURN: ext_trig_t = 1 for TURN_CYCLES cycles; synced input is ignored; then go to HOLDOFF.
- RX_WAIT: stay until the synced input is low, then go to HOLDOFF.
- HOLDOFF: count holdoff cycles, then go to IDLE.
  - holdoff = 0 returns to IDLE on the next cycle.
  - holdoff is sampled on entry to HOLDOFF.
  - Local edges arriving in HOLDOFF, TURN, RX_WAIT or DRIVE each increment drop_count.
  - External edges arriving outside IDLE are ignored and not counted.
- enable low:
  - From DRIVE → go to TURN on the next cycle (immediate release).
  - From any other state → go to IDLE once the current state completes.
  - While disabled, IDLE accepts no events.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values:
  - ext_trig_t = 1, ext_trig_rx = 0, busy = 0
  - All counters = 0; state = IDLE; synchronizer and edge registers cleared.
- Reset mid-DRIVE releases the line (ext_trig_t = 1) on the cycle after rst is sampled high.
- All outputs are registered.
- TX latency: pixel_trig rises at edge n → ext_trig_t = 0 from edge n+1. The line is low-driven-high for exactly max(drive_width,1) cycles.
- RX latency: pin rises before edge n → ext_trig_rx is high for the single cycle after edge n+SYNC_STAGES.
- Minimum TX-to-next-event spacing is max(drive_width,1) + TURN_CYCLES + holdoff + 1 cycles.
- A pixel_trig held high produces only one request; a new request needs a low cycle first.

## Structure
- Package ext_trig_pkg holds:
  - the state enum (IDLE, DRIVE, TURN, RX_WAIT, HOLDOFF)
  - the default SYNC_STAGES, TURN_CYCLES and CNT_W constants
- One sub-module, trig_sync_edge: N-stage synchronizer plus rising-edge detect.
  - Instantiated once for ext_trig_in.
  - pixel_trig uses only the edge-detect portion, with no synchronizer.
- The existing ext_trig IOBUF wrapper takes ext_trig_t as its T input, replacing its direct tie to pixel_trig.

## Test plan
- TX, basic: drive_width=5, holdoff=10, single pixel_trig pulse → ext_trig_t low for exactly 5 cycles starting 1 cycle after the edge; tx_count=1; busy for 5+4+10 cycles.
- Self-echo: loop ext_trig_in to the driven value with a 2-cycle delay → ext_trig_rx never pulses; rx_count=0.
- RX, basic: ext_trig_in high for 20 cycles → one ext_trig_rx pulse 3 cycles after the rise; rx_count=1; holdoff starts after the input falls.
- Collision and drop:
  - Local and external edges in the same cycle → RX path taken; drop_count=1; ext_trig_t stays 1.
  - Local edge during holdoff → drop_count increments.
- Edge cases:
  - drive_width=0 → 1-cycle drive.
  - enable dropped mid-DRIVE → line released next cycle.
  - rst mid-DRIVE → ext_trig_t=1 next cycle; all counters 0.
- Saturation: force more than 65535 dropped requests → drop_count holds at 0xFFFF.
